// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg
//   Shared types and helpers for the DDR read-burst test master.
//   - state_t        : master FSM states
//   - axi_arlen()    : AXI ARLEN encoding of a beat count (beats - 1)
//   - burst_len_ok() : legal AXI4 INCR burst length check (1..256)
//   - bytes_per_beat : byte lanes in one data beat
package ddr_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_ADDR     = 3'd2,
    ST_DATA     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int AXI_MAX_BURST_LEN = 256;

  function automatic logic [7:0] axi_arlen(input int burst_len);
    return 8'(burst_len - 1);
  endfunction

  function automatic bit burst_len_ok(input int burst_len);
    return (burst_len >= 1) && (burst_len <= AXI_MAX_BURST_LEN);
  endfunction

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ddr_rd_checker.sv
// ddr_rd_checker
//   Checks one read beat per cycle against the address-as-data pattern and
//   keeps the error statistics for a run.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     clr             : clears the statistics at the start of a run
//     beat_valid      : a beat is accepted this cycle (rvalid & rready)
//     beat_addr       : byte address of the accepted beat
//     rdata, rlast    : beat payload and last flag from the controller
//     last_exp        : this beat should be the last of its burst
//     err_cnt         : saturating count of erroneous beats
//     first_err_addr  : beat address of the first erroneous beat of the run
module ddr_rd_checker
  import ddr_test_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              beat_valid,
  input  logic [ADDR_W-1:0] beat_addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              last_exp,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [DATA_W-1:0] exp_data;
  logic              beat_err;
  logic [15:0]       err_cnt_reg;
  logic [ADDR_W-1:0] first_err_reg;

  // Expected data is the beat address, zero-extended or truncated to DATA_W.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_exp
      if (gi < ADDR_W) begin : g_addr_bit
        assign exp_data[gi] = beat_addr[gi];
      end else begin : g_zero_bit
        assign exp_data[gi] = 1'b0;
      end
    end
  endgenerate

  // A data mismatch and a misplaced rlast on the same beat count once.
  assign beat_err = beat_valid && ((rdata != exp_data) || (rlast != last_exp));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg   <= '0;
      first_err_reg <= '0;
    end else if (clr) begin
      err_cnt_reg   <= '0;
      first_err_reg <= '0;
    end else if (beat_err) begin
      if (err_cnt_reg == 16'd0) begin
        first_err_reg <= beat_addr;
      end
      if (err_cnt_reg != 16'hFFFF) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign err_cnt        = err_cnt_reg;
  assign first_err_addr = first_err_reg;

endmodule

// File: rtl/ddr_ctr_rd_burst_test.sv
// ddr_ctr_rd_burst_test
//   DDR read-test master. After ddr_ready it issues NUM_BURSTS INCR read
//   bursts of BURST_LEN beats over a contiguous window starting at BASE_ADDR,
//   one burst outstanding at a time, and checks every returned beat against
//   its own byte address.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     ddr_ready             : controller initialised
//     start                 : launches a run from IDLE or DONE
//     araddr/arlen/arvalid  : read-address channel (out), arready (in)
//     rdata/rvalid/rlast    : read-data channel (in), rready (out)
//     busy                  : run in progress
//     done                  : run complete (held until the next start)
//     err_cnt               : saturating mismatch count
//     first_err_addr        : beat address of the first mismatch
module ddr_ctr_rd_burst_test
  import ddr_test_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                BURST_LEN  = 16,
  parameter int                NUM_BURSTS = 4,
  parameter int                AUTO_START = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_ready,
  input  logic              start,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int BURST_CNT_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [ADDR_W-1:0]      BEAT_INC    = ADDR_W'(bytes_per_beat(DATA_W));
  localparam logic [ADDR_W-1:0]      BURST_INC   = ADDR_W'(BURST_LEN * bytes_per_beat(DATA_W));
  localparam logic [7:0]             ARLEN       = axi_arlen(BURST_LEN);
  localparam logic [BURST_CNT_W-1:0] LAST_BURST  = BURST_CNT_W'(NUM_BURSTS - 1);
  localparam state_t                 RESET_STATE = (AUTO_START != 0) ? ST_WAIT_RDY : ST_IDLE;

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      araddr_reg, araddr_next;
  logic [ADDR_W-1:0]      beat_addr_reg, beat_addr_next;
  logic [7:0]             beat_cnt_reg, beat_cnt_next;
  logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic                   arvalid_reg;
  logic                   rready_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   clr_errs;
  logic                   beat_fire;
  logic                   last_beat;

  assign beat_fire = rvalid && rready_reg;
  assign last_beat = (beat_cnt_reg == ARLEN);

  always_comb begin
    state_next     = state_reg;
    araddr_next    = araddr_reg;
    beat_addr_next = beat_addr_reg;
    beat_cnt_next  = beat_cnt_reg;
    burst_cnt_next = burst_cnt_reg;
    clr_errs       = 1'b0;
    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next     = ST_WAIT_RDY;
          araddr_next    = BASE_ADDR;
          beat_addr_next = BASE_ADDR;
          beat_cnt_next  = '0;
          burst_cnt_next = '0;
          clr_errs       = 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        if (ddr_ready) begin
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arvalid_reg && arready) begin
          state_next     = ST_DATA;
          beat_addr_next = araddr_reg;
          beat_cnt_next  = '0;
        end
      end
      ST_DATA: begin
        if (beat_fire) begin
          beat_addr_next = beat_addr_reg + BEAT_INC;
          beat_cnt_next  = beat_cnt_reg + 8'd1;
          if (last_beat) begin
            beat_cnt_next = '0;
            if (burst_cnt_reg == LAST_BURST) begin
              state_next = ST_DONE;
            end else begin
              burst_cnt_next = burst_cnt_reg + 1'b1;
              araddr_next    = araddr_reg + BURST_INC;
              state_next     = ST_ADDR;
            end
          end
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so each one
  // changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RESET_STATE;
      araddr_reg    <= BASE_ADDR;
      beat_addr_reg <= BASE_ADDR;
      beat_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      araddr_reg    <= araddr_next;
      beat_addr_reg <= beat_addr_next;
      beat_cnt_reg  <= beat_cnt_next;
      burst_cnt_reg <= burst_cnt_next;
      arvalid_reg   <= (state_next == ST_ADDR);
      rready_reg    <= (state_next == ST_DATA);
      busy_reg      <= (state_next == ST_WAIT_RDY) || (state_next == ST_ADDR) ||
                       (state_next == ST_DATA);
      done_reg      <= (state_next == ST_DONE);
    end
  end

  ddr_rd_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr_errs),
    .beat_valid     (beat_fire),
    .beat_addr      (beat_addr_reg),
    .rdata          (rdata),
    .rlast          (rlast),
    .last_exp       (last_beat),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  assign araddr  = araddr_reg;
  assign arlen   = ARLEN;
  assign arvalid = arvalid_reg;
  assign rready  = rready_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_ddr_ctr_rd_burst_test.sv
`timescale 1ns/1ps
module tb_ddr_ctr_rd_burst_test;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          BL     = 16;
  localparam int          NB     = 4;
  localparam int          BYTES  = DATA_W / 8;

  logic        clk = 1'b0;
  logic        rst, ddr_ready, start, arready, rvalid, rlast;
  logic [31:0] rdata;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, rready, busy, done;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;

  int n_cmp  = 0;
  int n_bad  = 0;
  int hs_cnt = 0;

  logic [31:0] bad_mask [NB][BL];
  bit          bad_last [NB][BL];

  int          last_m_err;
  logic [31:0] last_m_first;

  ddr_ctr_rd_burst_test #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BASE_ADDR  (BASE),
    .BURST_LEN  (BL),
    .NUM_BURSTS (NB),
    .AUTO_START (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ddr_ready      (ddr_ready),
    .start          (start),
    .araddr         (araddr),
    .arlen          (arlen),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .rlast          (rlast),
    .rready         (rready),
    .busy           (busy),
    .done           (done),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte address of beat k in burst b: contiguous window from BASE.
  function automatic logic [31:0] model_addr(input int b, input int k);
    return BASE + 32'((b * BL + k) * BYTES);
  endfunction

  task automatic clear_faults();
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < BL; k++) begin
        bad_mask[b][k] = '0;
        bad_last[b][k] = 1'b0;
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Acts as the DDR controller for one run and scores it against the model.
  task automatic serve_run(input string name, input int stall_min, input int stall_max,
                           input int gap_max, input int stop_after,
                           output int m_err, output logic [31:0] m_first);
    int          beats_done;
    int          waitc;
    int          stall;
    int          gaps;
    int          hs0;
    logic [31:0] a;
    logic [31:0] exp_d;
    bit          e;
    m_err      = 0;
    m_first    = '0;
    beats_done = 0;
    hs0        = hs_cnt;
    for (int b = 0; b < NB; b++) begin
      a     = model_addr(b, 0);
      waitc = 0;
      while (!arvalid && waitc < 200) begin
        step();
        waitc++;
      end
      n_cmp++;
      if (arvalid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_arvalid_timeout: burst %0d arvalid=%b, required 1 within 200 cycles",
                 name, b, arvalid);
        return;
      end
      stall = $urandom_range(stall_max, stall_min);
      for (int s = 0; s < stall; s++) begin
        arready = 1'b0;
        rvalid  = 1'($urandom_range(1, 0));
        rdata   = $urandom;
        rlast   = 1'($urandom_range(1, 0));
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== a || rready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_ar_stable: burst %0d stall %0d arvalid=%b araddr=%h rready=%b, required 1 %h 0",
                   name, b, s, arvalid, araddr, rready, a);
        end
        step();
      end
      rvalid  = 1'b0;
      rlast   = 1'b0;
      arready = 1'b1;
      n_cmp++;
      if (araddr !== a || arlen !== 8'(BL - 1) || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_ar_fields: burst %0d araddr=%h arlen=%0d busy=%b, required %h %0d 1",
                 name, b, araddr, arlen, busy, a, BL - 1);
      end
      step();
      arready = 1'b0;
      n_cmp++;
      if (arvalid !== 1'b0 || rready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_after_ar: burst %0d arvalid=%b rready=%b, required 0 1",
                 name, b, arvalid, rready);
      end
      for (int k = 0; k < BL; k++) begin
        gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        for (int g = 0; g < gaps; g++) begin
          rvalid = 1'b0;
          rdata  = $urandom;
          step();
        end
        exp_d  = model_addr(b, k);
        rvalid = 1'b1;
        rdata  = exp_d ^ bad_mask[b][k];
        rlast  = (k == BL - 1) ^ bad_last[b][k];
        e      = (bad_mask[b][k] != 0) || bad_last[b][k];
        if (e) begin
          if (m_err == 0) m_first = exp_d;
          if (m_err < 65535) m_err++;
        end
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
        beats_done++;
        if (stop_after >= 0 && beats_done == stop_after) return;
      end
      $display("%s: burst %0d at %h served, model errors %0d", name, b, a, m_err);
      if (b < NB - 1) begin
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== model_addr(b + 1, 0)) begin
          n_bad++;
          $display("FAIL %s_next_ar: after burst %0d arvalid=%b araddr=%h, required 1 %h",
                   name, b, arvalid, araddr, model_addr(b + 1, 0));
        end
      end else begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_done: done=%b busy=%b, required 1 0", name, done, busy);
        end
        n_cmp++;
        if (err_cnt !== 16'(m_err) || first_err_addr !== m_first) begin
          n_bad++;
          $display("FAIL %s_errors: err_cnt=%0d first_err_addr=%h, required %0d %h",
                   name, err_cnt, first_err_addr, m_err, m_first);
        end
        n_cmp++;
        if (hs_cnt - hs0 !== NB) begin
          n_bad++;
          $display("FAIL %s_handshakes: count=%0d, required %0d", name, hs_cnt - hs0, NB);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ddr_ready = 1'b0;
    start = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    rdata = '0;
    repeat (3) step();
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_handshake: arvalid=%b rready=%b, required 0 0", arvalid, rready);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy, done);
    end
    n_cmp++;
    if (err_cnt !== 16'd0 || first_err_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_errors: err_cnt=%0d first_err_addr=%h, required 0 0",
               err_cnt, first_err_addr);
    end
    n_cmp++;
    if (araddr !== BASE || arlen !== 8'(BL - 1)) begin
      n_bad++;
      $display("FAIL reset_addr: araddr=%h arlen=%0d, required %h %0d", araddr, arlen, BASE, BL - 1);
    end
    $display("reset: outputs sampled with rst high");
    rst = 1'b0;
  endtask

  task automatic test_auto_start();
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (arvalid !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL auto_wait_rdy: cycle %0d arvalid=%b busy=%b, required 0 1", c, arvalid, busy);
      end
    end
    ddr_ready = 1'b1;
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL auto_arvalid_early: arvalid=%b, required 0", arvalid);
    end
    step();
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== BASE) begin
      n_bad++;
      $display("FAIL auto_arvalid_rise: arvalid=%b araddr=%h, required 1 %h", arvalid, araddr, BASE);
    end
    clear_faults();
    serve_run("auto", 0, 0, 0, -1, last_m_err, last_m_first);
  endtask

  task automatic test_arready_stall();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL stall_start: busy=%b done=%b err_cnt=%0d, required 1 0 0", busy, done, err_cnt);
    end
    clear_faults();
    serve_run("stall", 10, 10, 0, -1, last_m_err, last_m_first);
  endtask

  task automatic test_error_injection();
    clear_faults();
    bad_mask[1][3]  = 32'h0000_0001;
    bad_last[2][14] = 1'b1;
    pulse_start();
    serve_run("inject", 0, 2, 1, -1, last_m_err, last_m_first);
    n_cmp++;
    if (err_cnt !== 16'd2 || first_err_addr !== 32'h0000_004C) begin
      n_bad++;
      $display("FAIL inject_summary: err_cnt=%0d first_err_addr=%h, required 2 0000004c",
               err_cnt, first_err_addr);
    end
  endtask

  task automatic test_random_traffic();
    int          r;
    logic [31:0] m;
    for (int run = 0; run < 3; run++) begin
      clear_faults();
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < BL; k++) begin
          r = $urandom_range(7, 0);
          m = $urandom;
          if (m == 0) m = 32'h8000_0000;
          if (r == 0 || r == 2) bad_mask[b][k] = m;
          if (r == 1 || r == 2) bad_last[b][k] = 1'b1;
        end
      pulse_start();
      n_cmp++;
      if (err_cnt !== 16'd0 || first_err_addr !== 32'd0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL random_clear: run %0d err_cnt=%0d first=%h done=%b, required 0 0 0",
                 run, err_cnt, first_err_addr, done);
      end
      serve_run("random", 0, 4, 3, -1, last_m_err, last_m_first);
    end
  endtask

  task automatic test_done_idle();
    for (int c = 0; c < 5; c++) begin
      rvalid = 1'b1;
      rdata  = $urandom;
      rlast  = 1'($urandom_range(1, 0));
      step();
      n_cmp++;
      if (rready !== 1'b0 || done !== 1'b1 || err_cnt !== 16'(last_m_err)) begin
        n_bad++;
        $display("FAIL done_ignore: cycle %0d rready=%b done=%b err_cnt=%0d, required 0 1 %0d",
                 c, rready, done, err_cnt, last_m_err);
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    $display("done_idle: stray beats ignored in DONE");
  endtask

  task automatic test_reset_mid();
    int          dummy_err;
    logic [31:0] dummy_first;
    clear_faults();
    bad_mask[0][2] = 32'h0000_0005;
    pulse_start();
    serve_run("midrst", 0, 1, 1, BL + 5, dummy_err, dummy_first);
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL midrst_busy: busy=%b done=%b err_cnt=%0d, required 1 0 1", busy, done, err_cnt);
    end
    rst    = 1'b1;
    start  = 1'b1;
    rvalid = 1'b1;
    rdata  = $urandom;
    step();
    rvalid = 1'b0;
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_ctrl: arvalid=%b rready=%b busy=%b done=%b, required 0 0 0 0",
               arvalid, rready, busy, done);
    end
    n_cmp++;
    if (err_cnt !== 16'd0 || first_err_addr !== 32'd0 || araddr !== BASE) begin
      n_bad++;
      $display("FAIL midrst_state: err_cnt=%0d first=%h araddr=%h, required 0 0 %h",
               err_cnt, first_err_addr, araddr, BASE);
    end
    rst   = 1'b0;
    start = 1'b0;
    clear_faults();
    serve_run("rerun", 0, 2, 2, -1, last_m_err, last_m_first);
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_arready_stall();
    test_error_injection();
    test_random_traffic();
    test_done_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_ctr_rd_burst_test.md
# ddr_ctr_rd_burst_test

Parametrised DDR read-test master: once the DDR controller reports ready, it issues a programmable sequence of AXI-style read bursts over a contiguous address window and consumes the read-data channel. Each returned beat is checked against an address-as-data pattern. Errors are counted and reported. It sits on the read-address and read-data ports of the DDR controller. It supersedes the single-beat, fixed-address read stimulus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, read-data width; multiple of 8, ≥ 32
- BASE_ADDR, 32'h0000_0000, byte address of first burst
- BURST_LEN, 16, beats per burst, 1..256; arlen = BURST_LEN-1
- NUM_BURSTS, 4, bursts per run, ≥ 1
- AUTO_START, 1, 1 = start a run after reset without `start`
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ddr_ready  in  1  DDR controller initialised
- start  in  1  one-cycle pulse; launches a run from IDLE or DONE
- araddr  out  ADDR_W  burst start byte address
- arlen  out  8  BURST_LEN-1, constant
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rdata  in  DATA_W  read data
- rvalid  in  1  read-data valid
- rlast  in  1  last beat of burst
- rready  out  1  read-data ready
- busy  out  1  run in progress
- done  out  1  sticky run-complete flag
- err_cnt  out  16  saturating mismatch count
- first_err_addr  out  ADDR_W  beat address of first mismatch

## Operation
- FSM states: IDLE, WAIT_RDY, ADDR, DATA, DONE.
- Reset values:
  - state = WAIT_RDY if AUTO_START, else IDLE.
  - arvalid = 0, rready = 0, busy = 0, done = 0, err_cnt = 0, first_err_addr = 0.
  - araddr = BASE_ADDR, burst and beat counters = 0.
- IDLE / DONE + start:
  - go to WAIT_RDY.
  - clear done, err_cnt and first_err_addr.
  - reload araddr = BASE_ADDR.
- WAIT_RDY + ddr_ready: go to ADDR and assert arvalid.
- ADDR:
  - hold arvalid, araddr and arlen stable until arvalid & arready.
  - on handshake: deassert arvalid, go to DATA.
- DATA:
  - rready = 1.
  - each beat where rvalid & rready:
    - expected = beat byte address (araddr + beat·DATA_W/8), zero-extended or truncated to DATA_W.
    - a mismatch on rdata is an error.
    - an rlast value that disagrees with (beat == BURST_LEN-1) is also an error.
    - one beat counts at most one error.
- End of a burst (the beat with beat == BURST_LEN-1):
  - if more bursts remain: araddr += BURST_LEN·DATA_W/8, go to ADDR.
  - otherwise: go to DONE, set done.
- err_cnt saturates at 16'hFFFF.
- first_err_addr latches only when err_cnt == 0 at the time of the error.
- busy = 1 in WAIT_RDY, ADDR and DATA.
- start is ignored while busy.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).

## Timing
- arvalid rises the cycle after ddr_ready is sampled high in WAIT_RDY.
- One burst outstanding at a time. arvalid never rises while the current burst's data is incomplete.
- AR handshake at cycle t: arvalid = 0 and rready = 1 at t+1.
- Final beat of a non-last burst at cycle t: arvalid = 1 with the new araddr at t+1.
- Final beat of the last burst at cycle t: done = 1 and busy = 0 at t+1.
- err_cnt and first_err_addr update the cycle after the offending beat.
- rready is deasserted in every state except DATA. rvalid outside DATA is ignored and not counted.
- rst mid-run: abandons the run immediately and returns to the reset values. Outstanding beats from the controller are not drained.
- start and rst in the same cycle: rst wins.

## Structure
- Package ddr_test_pkg:
  - FSM state enum.
  - AXI burst-length constant helpers.
  - bytes-per-beat function.
- Sub-module ddr_rd_checker: compare, rlast check, saturating counter and first-error latch, driven by beat valid, beat address and a last-beat flag.
- The top level holds the FSM, address generator and counters.

## Test plan
- AUTO_START=1, BURST_LEN=1, NUM_BURSTS=1:
  - ddr_ready high at cycle 5 → arvalid rises at cycle 6, araddr=0, arlen=0.
  - held until arready; done=1 after the single beat rdata=0, err_cnt=0.
- BURST_LEN=16, NUM_BURSTS=4, DATA_W=32, correct data:
  - araddr sequence 0x00, 0x40, 0x80, 0xC0.
  - done after 64 beats, err_cnt=0.
- arready stalled 10 cycles: arvalid and araddr stay stable throughout; exactly one handshake per burst.
- Corrupt beat 3 of burst 2 (expect 0x4C, drive 0x4D), plus rlast asserted early on beat 14 of burst 3:
  - err_cnt=2, first_err_addr=0x4C.
- rvalid toggled randomly during DATA: all beats checked; nothing counted while in ADDR or DONE.
- Reset asserted mid-burst 2:
  - all outputs return to their reset values.
  - a new start then re-runs cleanly from BASE_ADDR with err_cnt=0.
